// File: rtl/usb_rx_packet_writer_if.sv
// rtl/usb_rx_packet_writer_if.sv - FIFO fill-side bus between the RX packet writer and the transactional RX FIFO

// Write port plus transaction commit/rollback strobes of the RX FIFO
interface usb_rx_packet_writer_if #(
  parameter int DATA_WID = 8
);
  logic                dataValid;
  logic [DATA_WID-1:0] dataIn;
  logic                full;
  logic                fillTransDone;
  logic                fillTransSuccess;

  // Packet writer side: drives writes and transaction end, observes full
  modport master (
    output dataValid,
    output dataIn,
    output fillTransDone,
    output fillTransSuccess,
    input  full
  );

  // FIFO side
  modport slave (
    input  dataValid,
    input  dataIn,
    input  fillTransDone,
    input  fillTransSuccess,
    output full
  );
endinterface

// File: rtl/usb_rx_packet_writer.sv
// rtl/usb_rx_packet_writer.sv - CRC16-checked USB RX packet writer feeding the transactional RX FIFO

module usb_rx_packet_writer #(
  parameter int DATA_WID      = 8,
  parameter int MAX_PKT_BYTES = 64,
  parameter int LEN_WID       = 11
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                rxValid,
  input  logic [DATA_WID-1:0] rxData,
  input  logic                rxEop,
  input  logic                rxError,
  usb_rx_packet_writer_if.master fifo,
  output logic                pktDone,
  output logic                pktSuccess,
  output logic [LEN_WID-1:0]  pktLen
);

  localparam logic [1:0] ROLLBACK = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] RECV     = 2'd2;
  localparam logic [1:0] FINISH   = 2'd3;

  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'hA001;
  localparam logic [15:0] CRC_RESIDUAL = 16'hB001;

  localparam logic [LEN_WID-1:0] CNT_ONE = LEN_WID'(1);
  localparam logic [LEN_WID-1:0] CNT_TWO = LEN_WID'(2);
  // Byte count at which the implied payload length would pass MAX_PKT_BYTES
  localparam logic [LEN_WID-1:0] CNT_OVF = LEN_WID'(MAX_PKT_BYTES + 2);
  localparam logic [LEN_WID-1:0] CNT_SAT = LEN_WID'(MAX_PKT_BYTES + 3);

  logic [1:0]          state;
  logic [15:0]         crc;
  logic [LEN_WID-1:0]  byteCnt;
  logic [DATA_WID-1:0] hold0;      // most recent byte
  logic [DATA_WID-1:0] hold1;      // byte before that
  logic                overflow;
  logic                eopPend;    // EOP arrived together with a byte; finish next cycle
  logic                dataValidReg;
  logic [DATA_WID-1:0] dataInReg;
  logic                succReg;
  logic [LEN_WID-1:0]  pktLenReg;

  logic                lostWrite;
  logic                ovfNow;
  logic                pktGood;
  logic [LEN_WID-1:0]  cntNext;
  logic [LEN_WID-1:0]  lenCalc;

  // Reflected CRC16 update of one byte, LSB first
  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [DATA_WID-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < DATA_WID; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Packet verdict inputs: a write that met a full FIFO counts as overflow immediately
  always_comb begin
    lostWrite = dataValidReg && fifo.full;
    ovfNow    = overflow || lostWrite;
    cntNext   = (byteCnt == CNT_SAT) ? byteCnt : byteCnt + CNT_ONE;
    pktGood   = !ovfNow && (byteCnt >= CNT_TWO) && (crc == CRC_RESIDUAL);
    lenCalc   = (byteCnt >= CNT_TWO) ? byteCnt - CNT_TWO : '0;
  end

  // Packet FSM, CRC, two-byte CRC strip buffer and FIFO write register
  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= ROLLBACK;
      crc          <= CRC_INIT;
      byteCnt      <= '0;
      hold0        <= '0;
      hold1        <= '0;
      overflow     <= 1'b0;
      eopPend      <= 1'b0;
      dataValidReg <= 1'b0;
      dataInReg    <= '0;
      succReg      <= 1'b0;
      pktLenReg    <= '0;
    end else begin
      dataValidReg <= 1'b0;
      overflow     <= ovfNow;
      case (state)
        ROLLBACK: begin
          state <= IDLE;
        end
        IDLE: begin
          if (rxValid) begin
            crc      <= crcByte(CRC_INIT, rxData);
            byteCnt  <= CNT_ONE;
            hold0    <= rxData;
            overflow <= 1'b0;
            eopPend  <= 1'b0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (eopPend) begin
            state     <= FINISH;
            succReg   <= pktGood;
            pktLenReg <= lenCalc;
            eopPend   <= 1'b0;
          end else if (rxError) begin
            state     <= FINISH;
            succReg   <= 1'b0;
            pktLenReg <= lenCalc;
          end else begin
            if (rxValid) begin
              crc     <= crcByte(crc, rxData);
              byteCnt <= cntNext;
              hold1   <= hold0;
              hold0   <= rxData;
              if (byteCnt >= CNT_TWO) begin
                if (byteCnt >= CNT_OVF) begin
                  overflow <= 1'b1;
                end else if (!ovfNow) begin
                  dataValidReg <= 1'b1;
                  dataInReg    <= hold1;
                end
              end
            end
            if (rxEop) begin
              if (rxValid) begin
                eopPend <= 1'b1;
              end else begin
                state     <= FINISH;
                succReg   <= pktGood;
                pktLenReg <= lenCalc;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted
  always_comb begin
    fifo.dataValid        = !rst && dataValidReg;
    fifo.dataIn           = rst ? '0 : dataInReg;
    fifo.fillTransDone    = !rst && ((state == ROLLBACK) || (state == FINISH));
    fifo.fillTransSuccess = !rst && (state == FINISH) && succReg;
    pktDone               = !rst && (state == FINISH);
    pktSuccess            = !rst && succReg;
    pktLen                = rst ? '0 : pktLenReg;
  end

endmodule

// File: tb/tb_usb_rx_packet_writer.sv
// tb/tb_usb_rx_packet_writer.sv - directed self-checking bench for usb_rx_packet_writer

module tb_usb_rx_packet_writer;

  typedef logic [7:0] u8;
  typedef u8 u8q[$];

  logic        CLK = 1'b0;
  logic        rst;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxEop;
  logic        rxError;
  logic        full;
  logic        pktDone;
  logic        pktSuccess;
  logic [10:0] pktLen;

  int checks   = 0;
  int failures = 0;

  u8q   wq;
  int   doneCnt = 0;
  int   rbCnt = 0;
  int   dvInFinish = 0;
  logic lastFtd, lastFts, lastPs;
  int   lastLen;

  always #5 CLK = ~CLK;

  usb_rx_packet_writer_if #(.DATA_WID(8)) fifo ();
  assign fifo.full = full;

  usb_rx_packet_writer #(
    .DATA_WID(8),
    .MAX_PKT_BYTES(64),
    .LEN_WID(11)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .rxValid(rxValid),
    .rxData(rxData),
    .rxEop(rxEop),
    .rxError(rxError),
    .fifo(fifo.master),
    .pktDone(pktDone),
    .pktSuccess(pktSuccess),
    .pktLen(pktLen)
  );

  // Record FIFO writes and packet/rollback strobes mid-cycle
  always @(negedge CLK) begin
    if (fifo.dataValid) wq.push_back(fifo.dataIn);
    if (pktDone) begin
      doneCnt <= doneCnt + 1;
      lastFtd <= fifo.fillTransDone;
      lastFts <= fifo.fillTransSuccess;
      lastPs  <= pktSuccess;
      lastLen <= int'(pktLen);
      if (fifo.dataValid) dvInFinish <= dvInFinish + 1;
    end
    if (fifo.fillTransDone && !pktDone) rbCnt <= rbCnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] usbCrc(input u8q p);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    foreach (p[i]) begin
      b = p[i];
      for (int j = 0; j < 8; j++) begin
        if ((c[0] ^ b[0]) == 1'b1) c = {1'b0, c[15:1]} ^ 16'hA001;
        else                       c = {1'b0, c[15:1]};
        b = {1'b0, b[7:1]};
      end
    end
    return c;
  endfunction

  function automatic u8q withCrc(input u8q pl, input bit corrupt);
    u8q          b;
    logic [15:0] c;
    b = pl;
    c = ~usbCrc(pl);
    b.push_back(c[7:0]);
    b.push_back(c[15:8]);
    if (corrupt) b[b.size()-1] = b[b.size()-1] ^ 8'h01;
    return b;
  endfunction

  // Drive a byte stream, end it with EOP (separate or on the last byte) or an error,
  // then wait a bounded time for pktDone
  task automatic sendPkt(input string tag, input u8q b, input int fullAt,
                         input bit eopWithLast, input bit useErr);
    int prev;
    int n;
    wq.delete();
    prev = doneCnt;
    for (int i = 0; i < b.size(); i++) begin
      rxValid = 1'b1;
      rxData  = b[i];
      full    = (i == fullAt);
      rxEop   = eopWithLast && (i == b.size() - 1);
      tick();
    end
    rxValid = 1'b0;
    rxData  = 8'h00;
    full    = 1'b0;
    rxEop   = 1'b0;
    if (!eopWithLast) begin
      rxEop   = !useErr;
      rxError = useErr;
      tick();
      rxEop   = 1'b0;
      rxError = 1'b0;
    end
    n = 0;
    while (doneCnt == prev && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done"}, doneCnt, prev + 1);
  endtask

  task automatic checkWrites(input string tag, input u8q exp);
    int bad;
    check({tag, "_nwr"}, wq.size(), exp.size());
    bad = 0;
    foreach (exp[i]) if (i >= wq.size() || wq[i] !== exp[i]) bad++;
    check({tag, "_wdata"}, bad, 0);
  endtask

  task automatic checkDone(input string tag, input logic succ, input int len);
    check({tag, "_ftd"}, lastFtd, 1'b1);
    check({tag, "_fts"}, lastFts, succ);
    check({tag, "_pkts"}, lastPs, succ);
    check({tag, "_len"}, lastLen, len);
  endtask

  initial begin
    u8q pl;
    u8q b;
    u8q ex;
    int doneBefore;
    int rbBefore;

    rst = 1'b1; rxValid = 1'b0; rxData = 8'h00; rxEop = 1'b0; rxError = 1'b0; full = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_dv", fifo.dataValid, 1'b0);
    check("rst_ftd", fifo.fillTransDone, 1'b0);
    check("rst_fts", fifo.fillTransSuccess, 1'b0);
    check("rst_pktdone", pktDone, 1'b0);
    check("rst_pktlen", pktLen, 11'd0);
    rst = 1'b0;
    #3;
    check("rb_ftd", fifo.fillTransDone, 1'b1);
    check("rb_fts", fifo.fillTransSuccess, 1'b0);
    check("rb_pktdone", pktDone, 1'b0);
    tick();
    check("rb_once", fifo.fillTransDone, 1'b0);

    // 1: good 3-byte packet
    pl = '{8'h01, 8'h02, 8'h03};
    sendPkt("t1", withCrc(pl, 1'b0), -1, 1'b0, 1'b0);
    checkWrites("t1", pl);
    checkDone("t1", 1'b1, 3);

    // 2: last CRC byte corrupted
    sendPkt("t2", withCrc(pl, 1'b1), -1, 1'b0, 1'b0);
    checkWrites("t2", pl);
    checkDone("t2", 1'b0, 3);

    // 3: zero-length packet, CRC bytes 00 00
    b = '{8'h00, 8'h00};
    sendPkt("t3", b, -1, 1'b0, 1'b0);
    ex = {};
    checkWrites("t3", ex);
    checkDone("t3", 1'b1, 0);

    // 4: 8-byte payload, FIFO full during the 2nd write (cycle of byte index 4)
    pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    sendPkt("t4", withCrc(pl, 1'b0), 4, 1'b0, 1'b0);
    ex = '{8'h10, 8'h11};
    checkWrites("t4", ex);
    checkDone("t4", 1'b0, 8);

    // 5a: rxError after 5 bytes
    b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    sendPkt("t5a", b, -1, 1'b0, 1'b1);
    ex = '{8'h21, 8'h22, 8'h23};
    checkWrites("t5a", ex);
    checkDone("t5a", 1'b0, 3);

    // 5b: single byte then EOP
    b = '{8'h5A};
    sendPkt("t5b", b, -1, 1'b0, 1'b0);
    ex = {};
    checkWrites("t5b", ex);
    checkDone("t5b", 1'b0, 0);

    // EOP coinciding with the last CRC byte
    pl = '{8'hA5, 8'h5A, 8'hC3};
    sendPkt("teop", withCrc(pl, 1'b0), -1, 1'b1, 1'b0);
    checkWrites("teop", pl);
    checkDone("teop", 1'b1, 3);

    // Maximum payload of 64 bytes commits
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(u8'(i * 3 + 1));
    sendPkt("tmax", withCrc(pl, 1'b0), -1, 1'b0, 1'b0);
    checkWrites("tmax", pl);
    checkDone("tmax", 1'b1, 64);

    // 65-byte payload fails after 64 writes
    ex = pl;
    pl.push_back(8'hEE);
    sendPkt("tovf", withCrc(pl, 1'b0), -1, 1'b0, 1'b0);
    checkWrites("tovf", ex);
    checkDone("tovf", 1'b0, 65);

    check("no_dv_in_finish", dvInFinish, 0);

    // 6: reset mid-packet, while the first write would be on the bus
    doneBefore = doneCnt;
    rbBefore   = rbCnt;
    rxValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxData = u8'(8'h40 + i);
      tick();
    end
    rxValid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_dv", fifo.dataValid, 1'b0);
    check("t6_rst_ftd", fifo.fillTransDone, 1'b0);
    check("t6_rst_pktdone", pktDone, 1'b0);
    check("t6_rst_len", pktLen, 11'd0);
    tick();
    rst = 1'b0;
    #3;
    check("t6_rb_ftd", fifo.fillTransDone, 1'b1);
    check("t6_rb_fts", fifo.fillTransSuccess, 1'b0);
    check("t6_rb_pktdone", pktDone, 1'b0);
    tick();
    check("t6_rb_end", fifo.fillTransDone, 1'b0);
    pl = '{8'h77, 8'h88, 8'h99, 8'hAA};
    sendPkt("t6", withCrc(pl, 1'b0), -1, 1'b0, 1'b0);
    checkWrites("t6", pl);
    checkDone("t6", 1'b1, 4);
    check("t6_no_extra_done", doneCnt, doneBefore + 1);
    check("t6_one_rollback", rbCnt, rbBefore + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
